eight_bit_compressor_mul: RTL and testbench

//  Unsigned 8x8 -> 16-bit multiplier built on a compressor-tree partial-product reduction.

---
 rtl/eight_bit_compressor_mul.sv | 148 ++++++++++++++
 tb/tb_eight_bit_compressor_mul.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/eight_bit_compressor_mul.sv
// ---------------------------------------------------------------------------
// eight_bit_compressor_mul
//   Unsigned 8x8 -> 16-bit multiplier. The 64 AND partial products are laid
//   out as eight shifted 16-bit rows and reduced to two rows by a two-level
//   tree of 4:2 compressor rows (8 rows -> 4 -> 2), followed by a 16-bit
//   carry-propagate add into the registered product.
//
//   Build option: define CMP_PIPE_EN to insert a register after the reduction
//   tree (latency 2). Without it, reduction and CPA form one combinational
//   path into mult (latency 1). Both builds produce identical results.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; clears pipeline, mult, out_valid
//   in_valid   qualifies a/b this cycle
//   a, b       unsigned operands (W bits)
//   out_valid  mult holds a new product this cycle
//   mult       a*b (PW bits); holds its previous value while no product lands
// ---------------------------------------------------------------------------

// One row of 4:2 compressors across PW columns. Column k takes x1..x4 plus
// the lateral cin from column k-1 and emits sum (weight 2^k) plus carry and
// cout (both weight 2^(k+1)). cout depends only on x1..x3, so there is no
// ripple along the row. Carries leaving the top column are dropped: the row
// pair is only ever needed modulo 2^PW.
module cmp42_row #(
    parameter int PW = 16
) (
    input  logic [PW-1:0] x1,
    input  logic [PW-1:0] x2,
    input  logic [PW-1:0] x3,
    input  logic [PW-1:0] x4,
    output logic [PW-1:0] sum,
    output logic [PW-1:0] carry
);
    logic [PW-1:0] cin;    // cin[k] = cout of column k-1
    logic [PW-1:0] x123;

    assign cin[0]   = 1'b0;
    assign carry[0] = 1'b0;

    for (genvar k = 0; k < PW; k++) begin : g_col
        assign x123[k] = x1[k] ^ x2[k] ^ x3[k];
        assign sum[k]  = x123[k] ^ x4[k] ^ cin[k];
        if (k < PW-1) begin : g_up
            assign cin[k+1]   = (x1[k] & x2[k]) | (x1[k] & x3[k]) | (x2[k] & x3[k]);
            assign carry[k+1] = (x123[k] & x4[k]) | (x123[k] & cin[k]) | (x4[k] & cin[k]);
        end
    end
endmodule

module eight_bit_compressor_mul #(
    parameter int W  = 8,
    parameter int PW = 2*W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    output logic [PW-1:0] mult
);
`ifdef CMP_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    // Partial-product rows: row i holds pp[i][j] = a[j] & b[i] at bit i+j.
    // The zero padding at the row edges turns the corresponding compressor
    // cells into full/half adders (or wires) once constants propagate, which
    // is how the short columns at either end of the diagram get reduced.
    logic [W-1:0][PW-1:0] pp_row;
    for (genvar i = 0; i < W; i++) begin : g_pp
        assign pp_row[i] = PW'(a & {W{b[i]}}) << i;
    end

    // Level 1: rows 0-3 and rows 4-7 each compress to a sum/carry pair.
    logic [1:0][PW-1:0] l1_s, l1_c;
    for (genvar g = 0; g < 2; g++) begin : g_l1
        cmp42_row #(.PW(PW)) u_cmp (
            .x1    (pp_row[4*g]),
            .x2    (pp_row[4*g+1]),
            .x3    (pp_row[4*g+2]),
            .x4    (pp_row[4*g+3]),
            .sum   (l1_s[g]),
            .carry (l1_c[g])
        );
    end

    // Level 2: the four level-1 rows compress to the final two rows.
    logic [PW-1:0] row_s, row_c;
    cmp42_row #(.PW(PW)) u_l2 (
        .x1    (l1_s[0]),
        .x2    (l1_c[0]),
        .x3    (l1_s[1]),
        .x4    (l1_c[1]),
        .sum   (row_s),
        .carry (row_c)
    );

    // vld_pipe[s] is the valid bit s clocks after sampling in_valid.
    logic [STAGES:1] vld_pipe;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    logic [PW-1:0] cpa_s, cpa_c;
    logic          cpa_vld;

`ifdef CMP_PIPE_EN
    // Stage-1 register: loaded every clock, no stall.
    logic [PW-1:0] s_q, c_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            c_q <= '0;
        end else begin
            s_q <= row_s;
            c_q <= row_c;
        end
    end
    assign cpa_s   = s_q;
    assign cpa_c   = c_q;
    assign cpa_vld = vld_pipe[1];
`else
    assign cpa_s   = row_s;
    assign cpa_c   = row_c;
    assign cpa_vld = in_valid;
`endif

    // Final CPA; the carry out of the top bit is always 0 for W x W unsigned.
    logic [PW-1:0] product;
    assign product = cpa_s + cpa_c;

    always_ff @(posedge clk) begin
        if (!rst_n)       mult <= '0;
        else if (cpa_vld) mult <= product;
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_eight_bit_compressor_mul.sv
// Scoreboard bench for eight_bit_compressor_mul: each accepted operand pair
// pushes its product and due cycle; the monitor pops on the due cycle and
// otherwise requires out_valid=0 with mult holding its last value.
module tb_eight_bit_compressor_mul;
`ifdef CMP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_cur;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic [15:0] mult;
    logic        rst_d  = 1'b0;
    logic        mon_en = 1'b0;
    logic [15:0] model_mult = '0;

    eight_bit_compressor_mul dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .mult      (mult)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_d  <= rst_n;
        mon_en <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
        @(posedge clk);
        #1;
        in_valid = v;
        a        = x;
        b        = y;
        if (v && rst_n) sb.push_back('{16'(x) * 16'(y), cyc + LAT});
    endtask

    // Assert reset for n clocks; anything not yet out by the reset edge is lost.
    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!rst_d) begin
                    chk("rst_out_valid", 32'(out_valid), 32'd0);
                    chk("rst_mult", 32'(mult), 32'd0);
                    model_mult = '0;
                end else if (sb.size() > 0 && sb[0].due == cyc) begin
                    e_cur = sb.pop_front();
                    chk("out_valid", 32'(out_valid), 32'd1);
                    chk("mult", 32'(mult), 32'(e_cur.prod));
                    model_mult = e_cur.prod;
                end else begin
                    chk("idle_out_valid", 32'(out_valid), 32'd0);
                    chk("hold_mult", 32'(mult), 32'(model_mult));
                end
            end
        end
    end

    initial begin : stim
        // Reset held 2 clocks with max operands presented.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Directed cases with bubbles between them.
        drive(1'b1, 8'hAA, 8'hF0);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b1, 8'hFF, 8'hFF);
        drive(1'b0, 8'h55, 8'h55);
        drive(1'b1, 8'h00, 8'hB7);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b1, 8'h01, 8'h80);
        drive(1'b0, 8'h00, 8'h00);

        // Back-to-back.
        drive(1'b1, 8'h12, 8'h34);
        drive(1'b1, 8'h80, 8'h80);
        drive(1'b1, 8'h0F, 8'h11);
        repeat (3) drive(1'b0, 8'h00, 8'h00);

        // Reset one clock after issuing a product.
        drive(1'b1, 8'hAA, 8'hF0);
        reset_pulse(1);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 8'h00);

        // First valid after reset release, then a random stream with bubbles.
        drive(1'b1, 8'hC3, 8'h5A);
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
        drive(1'b0, 8'h00, 8'h00);

        // Exhaustive sweep, back-to-back.
        for (int ia = 0; ia < 256; ia++)
            for (int ib = 0; ib < 256; ib++)
                drive(1'b1, 8'(ia), 8'(ib));

        repeat (LAT + 3) drive(1'b0, 8'h00, 8'h00);
        chk("drain_pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
